instruction_fetch: RTL and testbench

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

---
 rtl/instruction_fetch_pkg.sv | 22 ++
 rtl/fetch_queue.sv | 83 ++++++++
 rtl/instruction_fetch.sv | 151 +++++++++++++++
 tb/tb_instruction_fetch.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/instruction_fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : instruction_fetch_pkg
// Description : Shared definitions for the instruction fetch slice: the NOP
//               word driven toward the decoder when idle, the default reset
//               PC, and the entry type stored in the fetch queues.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package instruction_fetch_pkg;

    // ADDI x0, x0, 0 -- the canonical RISC-V NOP.
    localparam logic [31:0] c_NOP_INSTR        = 32'h0000_0013;
    localparam logic [31:0] c_DEFAULT_RESET_PC = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry;

endpackage
`default_nettype wire

// File: rtl/fetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : fetch_queue
// Description : Small synchronous FIFO with flush. The element type is a
//               parameter (defaults to fetch_entry) so the same block serves
//               as the instruction queue and the in-flight address FIFO.
//               A push on a full queue is accepted when a pop happens in the
//               same cycle.
// Ports       : clk, rst (sync, active-high), i_flush, i_push/i_data,
//               i_pop, o_data (head), o_full, o_empty, o_count
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_queue
    import instruction_fetch_pkg::*;
#(
    parameter type ENTRY_T = fetch_entry,
    parameter int  DEPTH   = 2,
    localparam int c_CNT_W = $clog2(DEPTH + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_flush,
    input  logic               i_push,
    input  ENTRY_T             i_data,
    input  logic               i_pop,
    output ENTRY_T             o_data,
    output logic               o_full,
    output logic               o_empty,
    output logic [c_CNT_W-1:0] o_count
);

    localparam int                 c_PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [c_PTR_W-1:0] c_LAST  = c_PTR_W'(DEPTH - 1);

    ENTRY_T               r_mem [DEPTH];
    logic [c_PTR_W-1:0]   r_rd_ptr;
    logic [c_PTR_W-1:0]   r_wr_ptr;
    logic [c_CNT_W-1:0]   r_count;
    logic                 w_do_push;
    logic                 w_do_pop;

    function automatic logic [c_PTR_W-1:0] f_next(input logic [c_PTR_W-1:0] p);
        return (p == c_LAST) ? '0 : p + c_PTR_W'(1);
    endfunction

    assign o_full    = (r_count == c_CNT_W'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_data    = r_mem[r_rd_ptr];

    // Full queue still takes a push when the head leaves in the same cycle.
    assign w_do_pop  = i_pop & ~o_empty;
    assign w_do_push = i_push & (~o_full | w_do_pop);

    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= f_next(r_wr_ptr);
            end
            if (w_do_pop) begin
                r_rd_ptr <= f_next(r_rd_ptr);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + c_CNT_W'(1);
                2'b01:   r_count <= r_count - c_CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset; validity is tracked by the pointers and count.
    always_ff @(posedge clk) begin
        if (w_do_push && !rst && !i_flush) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

endmodule
`default_nettype wire

// File: rtl/instruction_fetch.sv
`default_nettype none
// ============================================================================
// Module      : instruction_fetch
// Description : Credit-limited instruction fetch unit. Issues word-aligned
//               requests to an in-order instruction memory, pairs each
//               response with its address and queues it for the decoder.
//               Redirects flush everything and drop responses that were
//               already in flight.
// Ports       : CLK, RSTN (sync, active-low)
//               IMEM_REQ_VALID/READY/ADDR      - fetch request channel
//               IMEM_RESP_VALID/DATA           - in-order response channel
//               REDIRECT_VALID/PC              - branch/jump/trap redirect
//               INSTR_VALID/READY, INSTRUCTION, PC - decoder channel
// Revision    : 1.0 - initial release
// ============================================================================
module instruction_fetch
    import instruction_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = c_DEFAULT_RESET_PC,
    parameter int          QUEUE_DEPTH = 2
) (
    input  logic        CLK,
    input  logic        RSTN,
    output logic        IMEM_REQ_VALID,
    input  logic        IMEM_REQ_READY,
    output logic [31:0] IMEM_REQ_ADDR,
    input  logic        IMEM_RESP_VALID,
    input  logic [31:0] IMEM_RESP_DATA,
    input  logic        REDIRECT_VALID,
    input  logic [31:0] REDIRECT_PC,
    output logic        INSTR_VALID,
    input  logic        INSTR_READY,
    output logic [31:0] INSTRUCTION,
    output logic [31:0] PC
);

    localparam int c_CNT_W  = $clog2(QUEUE_DEPTH + 1);
    // Stale responses can pile up across repeated redirects while new
    // requests keep issuing, so this counter is wider than the queue count.
    localparam int c_DISC_W = 8;

    logic                 w_rst;
    logic [29:0]          r_fetch_word;     // fetch PC without the always-zero low bits
    logic [c_DISC_W-1:0]  r_discard_cnt;
    logic [c_DISC_W-1:0]  w_pending_total;

    logic [c_CNT_W-1:0]   w_inflight_count;
    logic                 w_inflight_full;
    logic                 w_inflight_empty;
    logic [31:0]          w_inflight_addr;

    logic [c_CNT_W-1:0]   w_queue_count;
    logic                 w_queue_full;
    logic                 w_queue_empty;
    fetch_entry           w_queue_head;
    fetch_entry           w_queue_in;

    logic [c_CNT_W:0]     w_credit_used;
    logic                 w_has_credit;
    logic                 w_accept;
    logic                 w_resp_stale;
    logic                 w_resp_keep;
    logic                 w_instr_pop;
    logic                 w_unused_ok;

    assign w_rst = ~RSTN;

    // Requests in flight plus entries waiting for the decoder never exceed
    // the queue depth, so every kept response finds room in the queue.
    assign w_credit_used  = {1'b0, w_inflight_count} + {1'b0, w_queue_count};
    assign w_has_credit   = (w_credit_used < (c_CNT_W + 1)'(QUEUE_DEPTH));
    assign IMEM_REQ_VALID = RSTN & ~REDIRECT_VALID & w_has_credit
                          & ~w_inflight_full & ~w_queue_full;
    assign IMEM_REQ_ADDR  = {r_fetch_word, 2'b00};
    assign w_accept       = IMEM_REQ_VALID & IMEM_REQ_READY;

    // A response is stale while older redirects still owe discards; a
    // response in a redirect cycle is dropped and accounted for below.
    assign w_resp_stale = IMEM_RESP_VALID & (r_discard_cnt != '0);
    assign w_resp_keep  = IMEM_RESP_VALID & ~REDIRECT_VALID
                        & (r_discard_cnt == '0) & ~w_inflight_empty;

    assign INSTR_VALID  = RSTN & ~REDIRECT_VALID & ~w_queue_empty;
    assign w_instr_pop  = INSTR_VALID & INSTR_READY;
    assign INSTRUCTION  = INSTR_VALID ? w_queue_head.instr : c_NOP_INSTR;
    assign PC           = INSTR_VALID ? w_queue_head.pc    : 32'h0000_0000;

    assign w_queue_in = '{pc: w_inflight_addr, instr: IMEM_RESP_DATA};

    // Everything still owed by memory at a redirect: earlier stale responses
    // plus the live in-flight requests being abandoned now.
    assign w_pending_total = r_discard_cnt + c_DISC_W'(w_inflight_count);

    // Redirect targets are forced to word alignment; the low bits are ignored.
    assign w_unused_ok = &{1'b0, REDIRECT_PC[1:0]};

    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            r_fetch_word  <= RESET_PC[31:2];
            r_discard_cnt <= '0;
        end else if (REDIRECT_VALID) begin
            r_fetch_word  <= REDIRECT_PC[31:2];
            r_discard_cnt <= (IMEM_RESP_VALID && (w_pending_total != '0))
                           ? w_pending_total - c_DISC_W'(1)
                           : w_pending_total;
        end else begin
            if (w_accept) begin
                r_fetch_word <= r_fetch_word + 30'd1;   // wraps FFFF_FFFC -> 0
            end
            if (w_resp_stale) begin
                r_discard_cnt <= r_discard_cnt - c_DISC_W'(1);
            end
        end
    end

    // Addresses of live requests, popped as their responses come back.
    fetch_queue #(
        .ENTRY_T (logic [31:0]),
        .DEPTH   (QUEUE_DEPTH)
    ) u_inflight (
        .clk     (CLK),
        .rst     (w_rst),
        .i_flush (REDIRECT_VALID),
        .i_push  (w_accept),
        .i_data  (IMEM_REQ_ADDR),
        .i_pop   (w_resp_keep),
        .o_data  (w_inflight_addr),
        .o_full  (w_inflight_full),
        .o_empty (w_inflight_empty),
        .o_count (w_inflight_count)
    );

    // Fetched instructions waiting for the decoder.
    fetch_queue #(
        .ENTRY_T (fetch_entry),
        .DEPTH   (QUEUE_DEPTH)
    ) u_instr_queue (
        .clk     (CLK),
        .rst     (w_rst),
        .i_flush (REDIRECT_VALID),
        .i_push  (w_resp_keep),
        .i_data  (w_queue_in),
        .i_pop   (w_instr_pop),
        .o_data  (w_queue_head),
        .o_full  (w_queue_full),
        .o_empty (w_queue_empty),
        .o_count (w_queue_count)
    );

endmodule
`default_nettype wire

// File: tb/tb_instruction_fetch.sv
`default_nettype none
// ============================================================================
// Module      : tb_instruction_fetch
// Description : Directed bench for instruction_fetch. A 1-cycle in-order
//               memory model answers requests; expected decoder entries are
//               queued by each test and checked by an independent monitor.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instruction_fetch;
    import instruction_fetch_pkg::*;

    logic        CLK = 1'b0;
    logic        RSTN;
    logic        IMEM_REQ_VALID;
    logic        IMEM_REQ_READY;
    logic [31:0] IMEM_REQ_ADDR;
    logic        IMEM_RESP_VALID;
    logic [31:0] IMEM_RESP_DATA;
    logic        REDIRECT_VALID;
    logic [31:0] REDIRECT_PC;
    logic        INSTR_VALID;
    logic        INSTR_READY;
    logic [31:0] INSTRUCTION;
    logic [31:0] PC;

    instruction_fetch #(
        .RESET_PC    (32'h0000_0000),
        .QUEUE_DEPTH (2)
    ) dut (
        .CLK             (CLK),
        .RSTN            (RSTN),
        .IMEM_REQ_VALID  (IMEM_REQ_VALID),
        .IMEM_REQ_READY  (IMEM_REQ_READY),
        .IMEM_REQ_ADDR   (IMEM_REQ_ADDR),
        .IMEM_RESP_VALID (IMEM_RESP_VALID),
        .IMEM_RESP_DATA  (IMEM_RESP_DATA),
        .REDIRECT_VALID  (REDIRECT_VALID),
        .REDIRECT_PC     (REDIRECT_PC),
        .INSTR_VALID     (INSTR_VALID),
        .INSTR_READY     (INSTR_READY),
        .INSTRUCTION     (INSTRUCTION),
        .PC              (PC)
    );

    initial forever #5 CLK = ~CLK;

    int          nchk = 0;
    int          nerr = 0;
    fetch_entry  sb[$];
    logic [31:0] mem_pending[$];
    logic [31:0] acc_log[$];
    logic        mem_hold;
    logic        snap_req_valid;
    logic        snap_instr_valid;
    logic [31:0] snap_req_addr;
    logic [31:0] snap_instr;
    logic [31:0] snap_pc;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        nchk++;
        if (act !== req) begin
            nerr++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    task automatic expect_entry(input logic [31:0] pc, input logic [31:0] instr);
        sb.push_back('{pc: pc, instr: instr});
    endtask

    // One clock cycle, entered and left at a falling edge. Inputs set by the
    // caller are already applied; the memory model drives its response,
    // outputs are sampled after settling, and accepted requests are queued
    // so the memory answers them in the following cycle.
    task automatic cycle();
        if (!RSTN) begin
            mem_pending.delete();
            IMEM_RESP_VALID = 1'b0;
        end else if (!mem_hold && mem_pending.size() > 0) begin
            IMEM_RESP_VALID = 1'b1;
            IMEM_RESP_DATA  = mem_pending[0] ^ 32'hDEAD_0000;
            void'(mem_pending.pop_front());
        end else begin
            IMEM_RESP_VALID = 1'b0;
        end
        #1;
        snap_req_valid   = IMEM_REQ_VALID;
        snap_req_addr    = IMEM_REQ_ADDR;
        snap_instr_valid = INSTR_VALID;
        snap_instr       = INSTRUCTION;
        snap_pc          = PC;
        if (IMEM_REQ_VALID && IMEM_REQ_READY) begin
            mem_pending.push_back(IMEM_REQ_ADDR);
            acc_log.push_back(IMEM_REQ_ADDR);
        end
        @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic reset_dut();
        RSTN           = 1'b0;
        REDIRECT_VALID = 1'b0;
        IMEM_REQ_READY = 1'b0;
        mem_hold       = 1'b0;
        cycle();
        cycle();
        check("rst_req_valid", snap_req_valid, 0);
        check("rst_instr_valid", snap_instr_valid, 0);
        check("rst_instruction", snap_instr, 32'h0000_0013);
        check("rst_pc", snap_pc, 0);
        RSTN = 1'b1;
        acc_log.delete();
    endtask

    task automatic drain(input string name);
        for (int k = 0; k < 30 && sb.size() > 0; k++) cycle();
        check(name, sb.size(), 0);
    endtask

    // Monitor: every decoder handshake must match the next expected entry.
    initial begin
        forever begin
            @(negedge CLK);
            #2;
            if (INSTR_VALID && INSTR_READY) begin
                if (sb.size() == 0) begin
                    nchk++;
                    nerr++;
                    $display("FAIL unexpected_instr: got pc %h instr %h, required no entry", PC, INSTRUCTION);
                end else begin
                    fetch_entry e;
                    e = sb.pop_front();
                    check("instr_pc", PC, e.pc);
                    check("instr_word", INSTRUCTION, e.instr);
                end
            end
        end
    end

    initial begin
        RSTN            = 1'b0;
        IMEM_REQ_READY  = 1'b0;
        IMEM_RESP_VALID = 1'b0;
        IMEM_RESP_DATA  = 32'h0;
        REDIRECT_VALID  = 1'b0;
        REDIRECT_PC     = 32'h0;
        INSTR_READY     = 1'b1;
        mem_hold        = 1'b0;
        @(negedge CLK);

        // Reset release: addresses 0, 4, 8; first entry two cycles after accept.
        reset_dut();
        IMEM_REQ_READY = 1'b1;
        expect_entry(32'h0000_0000, 32'hDEAD_0000);
        expect_entry(32'h0000_0004, 32'hDEAD_0004);
        expect_entry(32'h0000_0008, 32'hDEAD_0008);
        cycle();
        check("first_req_valid", snap_req_valid, 1);
        check("first_req_addr", snap_req_addr, 32'h0000_0000);
        cycle();
        check("latency_not_early", snap_instr_valid, 0);
        cycle();
        check("latency_two_cycles", snap_instr_valid, 1);
        cycle();
        IMEM_REQ_READY = 1'b0;
        drain("stream_drained");
        check("stream_accepts", acc_log.size(), 3);
        if (acc_log.size() >= 3) begin
            check("stream_addr1", acc_log[1], 32'h0000_0004);
            check("stream_addr2", acc_log[2], 32'h0000_0008);
        end

        // Decoder stall: credits cap requests at two, head holds steady.
        reset_dut();
        INSTR_READY    = 1'b0;
        IMEM_REQ_READY = 1'b1;
        for (int i = 0; i < 10; i++) begin
            cycle();
            if (i == 4 || i == 9) begin
                check("stall_valid", snap_instr_valid, 1);
                check("stall_pc", snap_pc, 32'h0000_0000);
                check("stall_instr", snap_instr, 32'hDEAD_0000);
            end
        end
        check("stall_accepts", acc_log.size(), 2);
        IMEM_REQ_READY = 1'b0;
        INSTR_READY    = 1'b1;
        expect_entry(32'h0000_0000, 32'hDEAD_0000);
        expect_entry(32'h0000_0004, 32'hDEAD_0004);
        drain("stall_drained");

        // Two back-to-back redirects with two requests outstanding.
        reset_dut();
        INSTR_READY    = 1'b1;
        IMEM_REQ_READY = 1'b1;
        mem_hold       = 1'b1;
        cycle();
        cycle();
        cycle();
        check("redir_outstanding", acc_log.size(), 2);
        REDIRECT_VALID = 1'b1;
        REDIRECT_PC    = 32'h0000_0080;
        cycle();
        check("redir_no_req", snap_req_valid, 0);
        check("redir_no_instr", snap_instr_valid, 0);
        REDIRECT_PC    = 32'h0000_0102;
        cycle();
        REDIRECT_VALID = 1'b0;
        mem_hold       = 1'b0;
        expect_entry(32'h0000_0100, 32'hDEAD_0100);
        expect_entry(32'h0000_0104, 32'hDEAD_0104);
        cycle();
        check("redir_req_valid", snap_req_valid, 1);
        check("redir_req_addr", snap_req_addr, 32'h0000_0100);
        cycle();
        IMEM_REQ_READY = 1'b0;
        drain("redir_drained");

        // Redirect coinciding with the only outstanding response.
        reset_dut();
        INSTR_READY    = 1'b1;
        IMEM_REQ_READY = 1'b1;
        cycle();
        IMEM_REQ_READY = 1'b0;
        REDIRECT_VALID = 1'b1;
        REDIRECT_PC    = 32'h0000_0200;
        cycle();
        REDIRECT_VALID = 1'b0;
        IMEM_REQ_READY = 1'b1;
        expect_entry(32'h0000_0200, 32'hDEAD_0200);
        cycle();
        check("same_cycle_req_addr", snap_req_addr, 32'h0000_0200);
        check("same_cycle_no_stale", snap_instr_valid, 0);
        IMEM_REQ_READY = 1'b0;
        drain("same_cycle_drained");

        // Reset asserted with a full queue.
        reset_dut();
        INSTR_READY    = 1'b0;
        IMEM_REQ_READY = 1'b1;
        for (int i = 0; i < 5; i++) cycle();
        check("full_before_reset", snap_instr_valid, 1);
        RSTN = 1'b0;
        cycle();
        cycle();
        check("midrst_instr_valid", snap_instr_valid, 0);
        check("midrst_instruction", snap_instr, 32'h0000_0013);
        check("midrst_pc", snap_pc, 0);
        RSTN = 1'b1;
        acc_log.delete();
        cycle();
        check("midrst_first_req", snap_req_valid, 1);
        check("midrst_first_addr", snap_req_addr, 32'h0000_0000);
        check("midrst_queue_empty", snap_instr_valid, 0);
        IMEM_REQ_READY = 1'b0;

        // Fetch PC wrap-around at the top of the address space.
        reset_dut();
        INSTR_READY    = 1'b1;
        REDIRECT_VALID = 1'b1;
        REDIRECT_PC    = 32'hFFFF_FFFC;
        cycle();
        REDIRECT_VALID = 1'b0;
        IMEM_REQ_READY = 1'b1;
        expect_entry(32'hFFFF_FFFC, 32'h2152_FFFC);
        expect_entry(32'h0000_0000, 32'hDEAD_0000);
        cycle();
        check("wrap_addr_top", snap_req_addr, 32'hFFFF_FFFC);
        cycle();
        check("wrap_addr_zero", snap_req_addr, 32'h0000_0000);
        IMEM_REQ_READY = 1'b0;
        drain("wrap_drained");

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
`default_nettype wire
